editor_campos_rtc: RTL
======================

# editor_campos_rtc

Consumes the one-hot key commands produced by the PS/2 keyboard translator and turns them into edits of a BCD time register (hours, minutes, seconds) for the RTC controller. Sits directly downstream of the translator. It acknowledges each command over the translator's `S_DATA` clear line and raises a write request toward the RTC controller whenever a field changes. It also forwards the timer-toggle and alarm-stop keys as control outputs.

## Interface
- `HOR_MAX`, 8'h23: BCD maximum of the hours field.
- `MIN_MAX`, 8'h59: BCD maximum of the minutes and seconds fields.
- `Reloj`  in  1  system clock (100 MHz); every flop is on its rising edge.
- `RST`  in  1  reset, synchronous and active-low.
- `CMD`  in  8  translator command, one-hot:
  - bit5 = UP, bit4 = DO, bit3 = RI, bit2 = LE, bit1 = TO, bit0 = AS.
  - 8'h00 = no command.
- `EDIT_EN`  in  1  1 = edit mode; UP/DO/RI/LE take effect only when this is 1.
- `LOAD`  in  1  copies `RD_HOR`, `RD_MIN`, `RD_SEG` into the fields.
- `RD_HOR`, `RD_MIN`, `RD_SEG`  in  8 each  BCD time read back from the RTC.
- `WR_ACK`  in  1  RTC controller has accepted the current field values.
- `S_DATA`  out  1  registered acknowledge to the translator; its falling edge clears the translator's command.
- `HOR`, `MIN`, `SEG`  out  8 each  registered BCD field values.
- `CURSOR`  out  2  selected field: 0 = HOR, 1 = MIN, 2 = SEG.
- `WR_REQ`  out  1  write request level toward the RTC controller.
- `TIMER_ON`  out  1  timer enable, toggled by TO.
- `ALARM_STOP`  out  1  one-cycle pulse on AS.

## Operation
- Reset (`RST`=0 at a clock edge) sets:
  - fields 8'h00, `CURSOR` 0, state IDLE;
  - `S_DATA`, `WR_REQ`, `TIMER_ON`, `ALARM_STOP` all 0.
- Reset mid-handshake abandons the command; no edit is applied.
- FSM states: IDLE, ACK, CLR.
  - IDLE: when `CMD` is non-zero, execute it and go to ACK.
  - ACK: one cycle with `S_DATA`=1, then go to CLR.
  - CLR: `S_DATA`=0; stay until `CMD`==8'h00, then return to IDLE.
  - `CMD` is ignored in ACK and CLR, so a held command is never executed twice.
- A `CMD` with more than one bit set is invalid: it is acknowledged but has no effect.
- RI: `CURSOR` +1, wrapping 2→0. LE: `CURSOR` −1, wrapping 0→2.
- UP: BCD increment of the selected field.
  - Units 9 carries into tens.
  - At the maximum (`HOR_MAX` for hours, `MIN_MAX` for minutes/seconds) the field wraps to 8'h00.
  - No carry into any neighbouring field.
- DO: BCD decrement; units 0 borrows from tens; 8'h00 wraps to the field maximum.
- UP or DO sets `WR_REQ` to 1. `WR_REQ` holds until `WR_ACK`=1 is sampled, then clears.
- When `EDIT_EN`=0, UP/DO/RI/LE are acknowledged but change nothing.
- TO: `TIMER_ON` inverts. Honoured regardless of `EDIT_EN`.
- AS: `ALARM_STOP`=1 for exactly one cycle. Honoured regardless of `EDIT_EN`.
- LOAD: accepted only when `WR_REQ`=0 and no edit executes in the same cycle; otherwise it is ignored.
  - Each loaded byte with a nibble >9 or a value above its field maximum is stored as 8'h00.
  - `CURSOR` is unchanged by LOAD.
- Arithmetic is per nibble; results are always valid BCD within the field range.

## Timing
- A command sampled in IDLE at edge N produces at N+1:
  - field, `CURSOR`, `TIMER_ON`, `WR_REQ` and `ALARM_STOP` updates;
  - `S_DATA` high for the cycle N+1→N+2 only.
- `S_DATA` falls at N+2. The translator clears `CMD` several cycles later; the block waits in CLR until then, with no timeout.
- Minimum spacing between executed commands: 3 cycles.
- `WR_ACK` and a new UP/DO at the same edge: the edit wins and `WR_REQ` stays 1.
- `WR_ACK` while `WR_REQ`=0 has no effect.
- LOAD takes effect one cycle after it is sampled.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then `EDIT_EN`=1, `CMD`=8'h20 held for 10 cycles → `HOR` 8'h01 exactly once; `S_DATA` high for exactly one cycle; state returns to IDLE after `CMD`=0.
- `HOR`=8'h23 with `CURSOR`=0, UP → `HOR` 8'h00. Then DO → 8'h23. With `MIN`=8'h09, UP → 8'h10. With `SEG`=8'h00, DO → 8'h59.
- LE from `CURSOR`=0 → 2. RI from 2 → 0. `CMD`=8'h30 (two bits set) → acknowledged, no change.
- UP sets `WR_REQ`. A second UP before ack keeps it 1. `WR_ACK` pulse → `WR_REQ` 0 next cycle. `WR_ACK` coincident with UP → `WR_REQ` stays 1.
- `LOAD` with `RD_HOR`=8'h17, `RD_MIN`=8'h4A, `RD_SEG`=8'h30 and `WR_REQ`=0 → fields 8'h17, 8'h00, 8'h30. The same LOAD while `WR_REQ`=1 → fields unchanged.
- `EDIT_EN`=0: UP → fields unchanged but acknowledged. TO → `TIMER_ON` 1. AS → `ALARM_STOP` high for one cycle. `RST`=0 during ACK → all outputs 0 at the next edge.

Source files
------------

// File: rtl/editor_campos_rtc.sv
// Turns one-hot keyboard commands into BCD edits of an hours/minutes/seconds register,
// acknowledging each command to the translator and requesting a write to the RTC.
module editor_campos_rtc #(
    parameter logic [7:0] HOR_MAX = 8'h23,
    parameter logic [7:0] MIN_MAX = 8'h59
) (
    input  logic       Reloj,
    input  logic       RST,
    input  logic [7:0] CMD,
    input  logic       EDIT_EN,
    input  logic       LOAD,
    input  logic [7:0] RD_HOR,
    input  logic [7:0] RD_MIN,
    input  logic [7:0] RD_SEG,
    input  logic       WR_ACK,
    output logic       S_DATA,
    output logic [7:0] HOR,
    output logic [7:0] MIN,
    output logic [7:0] SEG,
    output logic [1:0] CURSOR,
    output logic       WR_REQ,
    output logic       TIMER_ON,
    output logic       ALARM_STOP
);

    localparam logic [7:0] CMD_UP = 8'h20;
    localparam logic [7:0] CMD_DO = 8'h10;
    localparam logic [7:0] CMD_RI = 8'h08;
    localparam logic [7:0] CMD_LE = 8'h04;
    localparam logic [7:0] CMD_TO = 8'h02;
    localparam logic [7:0] CMD_AS = 8'h01;

    typedef enum logic [1:0] {IDLE, ACK, CLR} state_t;

    state_t     state;
    logic       do_exec;
    logic       cmd_valid;
    logic       do_edit;
    logic [7:0] sel_field;
    logic [7:0] sel_max;
    logic [7:0] edit_val;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) return max;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Valid BCD bytes order the same as their decimal values, so a plain compare checks range
    function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] max);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) return 8'h00;
        return v;
    endfunction

    always_comb begin
        do_exec   = (state == IDLE) && (CMD != 8'h00);
        cmd_valid = (CMD == CMD_UP) || (CMD == CMD_DO) || (CMD == CMD_RI) ||
                    (CMD == CMD_LE) || (CMD == CMD_TO) || (CMD == CMD_AS);
        do_edit   = do_exec && EDIT_EN && ((CMD == CMD_UP) || (CMD == CMD_DO));
        sel_field = HOR;
        sel_max   = HOR_MAX;
        case (CURSOR)
            2'd1: begin
                sel_field = MIN;
                sel_max   = MIN_MAX;
            end
            2'd2: begin
                sel_field = SEG;
                sel_max   = MIN_MAX;
            end
            default: ;
        endcase
        edit_val = (CMD == CMD_UP) ? bcd_inc(sel_field, sel_max) : bcd_dec(sel_field, sel_max);
    end

    // Commands are executed only on entry from IDLE, so a held key acts once
    always_ff @(posedge Reloj) begin
        if (!RST) begin
            state      <= IDLE;
            S_DATA     <= 1'b0;
            HOR        <= 8'h00;
            MIN        <= 8'h00;
            SEG        <= 8'h00;
            CURSOR     <= 2'd0;
            WR_REQ     <= 1'b0;
            TIMER_ON   <= 1'b0;
            ALARM_STOP <= 1'b0;
        end else begin
            ALARM_STOP <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_exec) begin
                        S_DATA <= 1'b1;
                        state  <= ACK;
                        if (cmd_valid) begin
                            case (CMD)
                                CMD_RI: if (EDIT_EN) CURSOR <= (CURSOR == 2'd2) ? 2'd0 : CURSOR + 2'd1;
                                CMD_LE: if (EDIT_EN) CURSOR <= (CURSOR == 2'd0) ? 2'd2 : CURSOR - 2'd1;
                                CMD_TO: TIMER_ON   <= ~TIMER_ON;
                                CMD_AS: ALARM_STOP <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                ACK: begin
                    S_DATA <= 1'b0;
                    state  <= CLR;
                end
                CLR: begin
                    if (CMD == 8'h00) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (do_edit) begin
                case (CURSOR)
                    2'd1:    MIN <= edit_val;
                    2'd2:    SEG <= edit_val;
                    default: HOR <= edit_val;
                endcase
            end else if (LOAD && !WR_REQ) begin
                HOR <= bcd_clean(RD_HOR, HOR_MAX);
                MIN <= bcd_clean(RD_MIN, MIN_MAX);
                SEG <= bcd_clean(RD_SEG, MIN_MAX);
            end

            // A fresh edit outranks a coincident acknowledge of the previous one
            if (do_edit) WR_REQ <= 1'b1;
            else if (WR_ACK) WR_REQ <= 1'b0;
        end
    end

endmodule
